palette_ram: RTL
================

PALETTE_RAM -- requirements
Module: palette_ram

Interface
REQ-001 Parameter DW, 16, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, 8, address width; depth = 2^AW entries.
REQ-003 Parameter INIT_CLEAR, 1, when 1 the block SHALL zero all entries after reset.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RESETn  input  1  reset, asynchronous, active-low.
REQ-006 CS1, CS2  input  1 each  chip selects; block selected only when both high.
REQ-007 WR  input  1  CPU write strobe, sampled on CLK.
REQ-008 RD  input  1  CPU read strobe, sampled on CLK.
REQ-009 REG  input  1  1 = index register access, 0 = palette data access.
REQ-010 BE  input  DW/8  byte enables for data writes.
REQ-011 DI  input  DW  CPU write data.
REQ-012 DO  output  DW  CPU read data, registered.
REQ-013 DE  output  DW  DO drive enable, combinational.
REQ-014 VA  input  AW  video lookup address.
REQ-015 VO  output  DW  video lookup data, registered.
REQ-016 BUSY  output  1  clear sequence in progress.

Function
REQ-017 Selected = CS1 & CS2; WR/RD SHALL be ignored when not selected.
REQ-018 DE SHALL be all ones when selected & RD & ~WR, else all zeros.
REQ-019 Index register IDX (AW bits): selected WR with REG=1 SHALL load IDX <= DI[AW-1:0].
REQ-020 Selected WR with REG=0 SHALL write mem[IDX] byte lanes where BE[n]=1, keep other lanes, then IDX <= IDX+1 mod 2^AW.
REQ-021 Selected RD with REG=0 SHALL set DO <= mem[IDX] on the next edge (latency 1) and IDX <= IDX+1 mod 2^AW.
REQ-022 Selected RD with REG=1 SHALL set DO <= IDX zero-extended to DW; IDX unchanged.
REQ-023 WR and RD both asserted in the same cycle: write SHALL be performed, read ignored, DO held.
REQ-024 DO SHALL hold its value when no read occurs.
REQ-025 VO SHALL be updated every cycle with mem[VA], latency 1.
REQ-026 Same-cycle CPU data write to address == VA: VO SHALL return the merged new word (write-first bypass).
REQ-027 IDX wrap: at IDX = 2^AW-1, an auto-increment SHALL produce 0.
REQ-028 FSM states CLEAR and IDLE; after reset state = CLEAR if INIT_CLEAR=1, else IDLE.
REQ-029 CLEAR: write zero to entry CNT, CNT increments 0..2^AW-1 one per cycle; after entry 2^AW-1 go to IDLE.
REQ-030 BUSY SHALL be 1 exactly while state = CLEAR.
REQ-031 During CLEAR, CPU writes (data and index) SHALL be dropped, CPU reads SHALL load DO <= 0 without changing IDX, VO SHALL be 0.
REQ-032 With INIT_CLEAR=0, memory contents after power-up are undefined and SHALL NOT be altered by reset.

Reset
REQ-033 RESETn low SHALL immediately set IDX=0, CNT=0, DO=0, VO=0, BUSY=INIT_CLEAR, state per REQ-028.
REQ-034 Reset asserted mid-CLEAR SHALL restart the clear from entry 0 after release.
REQ-035 Reset SHALL not alter IDLE-mode memory beyond the clear sequence of REQ-029.

Verification
REQ-036 Release reset, DW=16 AW=8 INIT_CLEAR=1 -> BUSY=1 for exactly 256 cycles, then every entry reads 0x0000.
REQ-037 Write IDX=0xFE, data writes 0x1234, 0xABCD, 0x5555 -> entries 0xFE=0x1234, 0xFF=0xABCD, 0x00=0x5555, IDX reads back 0x01.
REQ-038 Entry 0x10=0x1234, write 0xFF00 with BE=2'b01 -> entry reads 0x1200.
REQ-039 VA=0x20 held, CPU writes 0x7E7E to 0x20 -> VO=0x7E7E on the following edge, no stale cycle.
REQ-040 WR and RD asserted together with CS1=CS2=1 -> write performed, DO unchanged, DE=0; CS2=0 with RD -> DE=0, DO unchanged.
REQ-041 Pulse RESETn low at clear count 100 -> BUSY remains 1 for a full 256 cycles after release.

Source files
------------

// File: rtl/palette_ram_if.sv
// CPU-side and video-side signal bundle for palette_ram.
// The master drives strobes, data and the video address; the slave returns read data,
// drive enable, video data and the busy flag.
interface palette_ram_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic            cs1;
    logic            cs2;
    logic            wr;
    logic            rd;
    logic            regsel;   // 1 = index register, 0 = palette data
    logic [DW/8-1:0] be;
    logic [DW-1:0]   di;
    logic [DW-1:0]   dout;
    logic [DW-1:0]   de;
    logic [AW-1:0]   va;
    logic [DW-1:0]   vo;
    logic            busy;

    modport master (
        output cs1, cs2, wr, rd, regsel, be, di, va,
        input  dout, de, vo, busy
    );

    modport slave (
        input  cs1, cs2, wr, rd, regsel, be, di, va,
        output dout, de, vo, busy
    );
endinterface

// File: rtl/palette_ram.sv
// Palette RAM: CPU port with an auto-incrementing index register and byte-lane writes,
// plus a free-running video lookup port with write-first bypass. An optional clear
// sequence zeroes every entry after reset while BUSY is high.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | normal operation, CPU and video ports live
// S_CLEAR | zeroing entry cnt each cycle; CPU writes dropped, reads give 0
module palette_ram #(
    parameter int DW         = 16,
    parameter int AW         = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic           clk,
    input  logic           resetn,
    palette_ram_if.slave   bus
);
    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic [AW-1:0] cnt;
    logic [DW-1:0] dout_q;
    logic [DW-1:0] vo_q;
    logic          busy_q;
    logic [DW-1:0] mem [DEPTH];

    logic          sel;
    logic          clearing;
    logic          wr_any;
    logic          wr_data;
    logic          wr_idx;
    logic          rd_any;
    logic [DW-1:0] wmerge;

    assign sel      = bus.cs1 & bus.cs2;
    assign clearing = (state == S_CLEAR);
    // A write wins over a simultaneous read; the read is then simply ignored.
    assign wr_any   = sel & bus.wr & ~clearing;
    assign wr_data  = wr_any & ~bus.regsel;
    assign wr_idx   = wr_any & bus.regsel;
    assign rd_any   = sel & bus.rd & ~bus.wr;

    assign bus.de   = rd_any ? '1 : '0;
    assign bus.dout = dout_q;
    assign bus.vo   = vo_q;
    assign bus.busy = busy_q;

    // Merge enabled byte lanes of the write data into the currently indexed word.
    always_comb begin
        wmerge = mem[idx];
        for (int n = 0; n < NB; n++) begin
            if (bus.be[n]) begin
                wmerge[8*n +: 8] = bus.di[8*n +: 8];
            end
        end
    end

    // Storage array; deliberately not reset so reset never disturbs contents.
    always_ff @(posedge clk) begin
        if (clearing) begin
            mem[cnt] <= '0;
        end else if (wr_data) begin
            mem[idx] <= wmerge;
        end
    end

    // Sequencer, index register and registered CPU/video outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= (INIT_CLEAR != 0) ? S_CLEAR : S_IDLE;
            busy_q <= (INIT_CLEAR != 0);
            cnt    <= '0;
            idx    <= '0;
            dout_q <= '0;
            vo_q   <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    cnt  <= cnt + AW'(1);
                    vo_q <= '0;
                    if (rd_any) begin
                        dout_q <= '0;
                    end
                    if (cnt == AW'(DEPTH - 1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (wr_idx) begin
                        idx <= bus.di[AW-1:0];
                    end else if (wr_data) begin
                        idx <= idx + AW'(1);
                    end else if (rd_any) begin
                        if (bus.regsel) begin
                            dout_q <= DW'(idx);
                        end else begin
                            dout_q <= mem[idx];
                            idx    <= idx + AW'(1);
                        end
                    end
                    // Write-first: a same-cycle write to the looked-up entry is visible at once.
                    vo_q <= (wr_data && (idx == bus.va)) ? wmerge : mem[bus.va];
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
